cluster_set_serializer: RTL and testbench
=========================================

# cluster_set_serializer

Downstream stage of the 8-cluster selector in the cluster packer. Captures each qualified set of eight `{cnt, adr}` clusters into a two-bank ping-pong buffer, discards invalid slots, and streams the valid clusters one 14-bit word per clock over a valid/ready interface to the link formatter. Sets that arrive while both banks are occupied are dropped and counted.

## Interface
Parameters:
- `INVALID_ADR`, 11'h7FE: address value marking an empty cluster slot.
- `OVF_CNT_W`, 16: width of the saturating overflow counter.

Ports:
- `clock4x`  in  1  sole clock.
- `global_reset_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  one-cycle strobe; the eight cluster inputs are valid this cycle.
- `adr0`..`adr7`  in  11 each  cluster addresses; slot 0 is highest priority.
- `cnt0`..`cnt7`  in  3 each  cluster sizes.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  14  `{cnt, adr}`, or a header word (see Configuration).
- `out_last`  out  1  final word of the current set.
- `out_is_header`  out  1  word is a set header; constant 0 without the macro.
- `overflow`  out  1  one-cycle pulse: an incoming set was dropped.
- `overflow_cnt`  out  OVF_CNT_W  saturating count of dropped sets.

## Operation
- Slot k is valid iff `adrk != INVALID_ADR`. `cnt` is not checked.
- Banks 0/1 each hold eight 14-bit entries, an 8-bit valid mask, and a `full` flag. `wr_bank` and `rd_bank` pointers both reset to 0.
- Capture on `in_valid`:
  - Mask nonzero, or macro on: write all eight entries and the mask into `wr_bank`, set its `full`, toggle `wr_bank`.
  - Mask zero and macro off: no-op. Not an overflow.
  - Target bank full and not released this cycle: drop the set, pulse `overflow`, increment `overflow_cnt` (saturates at all-ones).
- Drain: while `rd_bank` is full, `out_data` is the entry at the lowest set bit of its mask, found by a priority encoder.
  - On handshake (`out_valid && out_ready`): clear that mask bit.
  - `out_last` = 1 when exactly one mask bit remains (or header with empty mask).
  - Handshake on the last word: clear `full`, toggle `rd_bank`.
- A bank released on cycle N is writable by an `in_valid` on cycle N (release takes priority in the free check).
- `out_valid` = `full[rd_bank]`. While `out_valid && !out_ready`, `out_data`, `out_last` and `out_is_header` hold stable.

## Timing
- All outputs reset to 0, including `overflow_cnt`. Banks empty; pointers 0.
- Latency: `in_valid` on edge N gives `out_valid` high after edge N (cycle N+1) if the bank was empty and the reader was idle.
- Throughput: one word per clock with `out_ready` held high. No bubble between banks.
- Sustained input rate: one set per 4 clocks. Up to 4 valid clusters per set drain with no loss under continuous `out_ready`.
- `overflow` is registered: it pulses the cycle after the dropped `in_valid`.
- Reset asserted mid-drain: immediate clear, no partial words. The first `in_valid` after deassertion goes to bank 0.

## Configuration
- `CLUSTER_SET_HEADER_EN` defined:
  - Every captured set, including all-invalid ones, is preceded by one header word with `out_is_header`=1.
  - Header `out_data` = `{3'b000, seq[6:0], nvalid[3:0]}`. `seq` is a 7-bit count of captured sets: reset 0, wraps 127→0, excludes dropped sets. `nvalid` is the number of valid clusters (0–8).
  - Empty set: header only, with `out_last`=1.
- Undefined: no headers, `out_is_header` tied 0, empty sets ignored.

## Structure
- Package `cluster_pkg`: `MXADRB`=11, `MXCNTB`=3, `INVALID_ADR_DEF`, `cluster_t` packed struct `{cnt, adr}`, `NCLUST_SET`=8.
- Sub-module `first_valid8`: 8-bit mask in, 3-bit lowest-set index plus `any` flag out, combinational. Used once for the read bank.

## Test plan
- Reset release, then one set with valid slots 0,3,7 (`adr` 5,200,1535), `out_ready`=1 → words 5,200,1535 on cycles N+1..N+3, `out_last` on 1535 only.
- All slots `adr`=7FE, macro off → `out_valid` stays 0, `overflow_cnt` stays 0. Macro on → single header `{0,seq=0,nvalid=0}` with `out_last`.
- `out_ready`=0, three full sets 4 clocks apart → first two buffered; third drops, `overflow` pulses, `overflow_cnt`=1. Data is stable throughout the stall.
- Backpressure toggled every other cycle over an 8-valid set → exactly 8 words, in slot order, none duplicated or skipped.
- Last-word handshake coincides with `in_valid` while both banks full → new set accepted, no overflow.
- `global_reset_n` pulsed low mid-drain → `out_valid` falls asynchronously; after release, the next set goes to bank 0 and `seq` restarts at 0.

Source files
------------

// File: rtl/cluster_pkg.sv
// cluster_pkg: shared widths, the packed cluster word and a small popcount
// helper for the cluster set serializer slice.
package cluster_pkg;

  localparam int MXADRB     = 11;
  localparam int MXCNTB     = 3;
  localparam int NCLUST_SET = 8;

  localparam logic [MXADRB-1:0] INVALID_ADR_DEF = 11'h7FE;

  // One cluster word as it leaves the serializer: {cnt, adr}.
  typedef struct packed {
    logic [MXCNTB-1:0] cnt;
    logic [MXADRB-1:0] adr;
  } cluster_t;

  // Number of set bits in an 8-bit slot mask (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'b000, m[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/first_valid8.sv
// first_valid8: combinational priority encoder, lowest set bit wins.
//   mask_i : 8-bit request mask
//   idx_o  : index of the lowest set bit (0 when mask_i is empty)
//   any_o  : mask_i has at least one bit set
module first_valid8
  import cluster_pkg::*;
(
  input  logic [NCLUST_SET-1:0] mask_i,
  output logic [2:0]            idx_o,
  output logic                  any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = 3'd0;
    any_o = 1'b0;
    for (int k = NCLUST_SET - 1; k >= 0; k--) begin
      if (mask_i[k]) begin
        idx_o = 3'(k);
        any_o = 1'b1;
      end else begin
        // lower slot not requesting: keep the result found so far
      end
    end
  end

endmodule

// File: rtl/cluster_set_serializer.sv
// cluster_set_serializer: captures sets of eight {cnt, adr} clusters into a
// two-bank ping-pong buffer and streams the valid ones, lowest slot first,
// one 14-bit word per clock over valid/ready. Sets arriving while the target
// bank is still occupied are dropped and counted.
//
// Optional feature: define CLUSTER_SET_HEADER_EN to prefix every captured set
// (including all-invalid sets) with a header word {3'b000, seq, nvalid}.
//
// Ports:
//   clock4x, global_reset_n    clock, async active-low reset
//   in_valid, adr0..7, cnt0..7 incoming cluster set strobe and slots
//   out_valid/out_ready        stream handshake
//   out_data, out_last         word and end-of-set marker
//   out_is_header              header word marker (0 without the feature)
//   overflow, overflow_cnt     drop pulse and saturating drop counter
module cluster_set_serializer
  import cluster_pkg::*;
#(
  parameter logic [MXADRB-1:0] INVALID_ADR = INVALID_ADR_DEF,
  parameter int                OVF_CNT_W   = 16
) (
  input  logic                 clock4x,
  input  logic                 global_reset_n,
  input  logic                 in_valid,
  input  logic [MXADRB-1:0]    adr0, adr1, adr2, adr3,
  input  logic [MXADRB-1:0]    adr4, adr5, adr6, adr7,
  input  logic [MXCNTB-1:0]    cnt0, cnt1, cnt2, cnt3,
  input  logic [MXCNTB-1:0]    cnt4, cnt5, cnt6, cnt7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [13:0]          out_data,
  output logic                 out_last,
  output logic                 out_is_header,
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] overflow_cnt
);

  cluster_t                in_set_s [NCLUST_SET];
  logic [NCLUST_SET-1:0]   in_mask_s;

  cluster_t                bank_q [2][NCLUST_SET];
  logic [NCLUST_SET-1:0]   mask_q [2];
  logic [NCLUST_SET-1:0]   mask_d [2];
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    overflow_q, overflow_d;
  logic [OVF_CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;

  logic [NCLUST_SET-1:0]   rd_mask_s;
  logic [2:0]              rd_idx_s;
  logic                    rd_any_s;
  logic                    rd_one_left_s;
  cluster_t                rd_word_s;
  logic                    hdr_active_s;
  logic [13:0]             hdr_data_s;
  logic                    handshake_s;
  logic                    release_s;
  logic                    capture_s;
  logic                    bank_free_s;
  logic                    accept_s;

`ifdef CLUSTER_SET_HEADER_EN
  logic [1:0]              hdr_pend_q, hdr_pend_d;
  logic [13:0]             hdr_word_q [2];
  logic [13:0]             hdr_word_d [2];
  logic [6:0]              seq_q, seq_d;
`endif

  // Gather the eight input slots and flag the ones carrying a real address.
  always_comb begin
    in_set_s[0] = '{cnt: cnt0, adr: adr0};
    in_set_s[1] = '{cnt: cnt1, adr: adr1};
    in_set_s[2] = '{cnt: cnt2, adr: adr2};
    in_set_s[3] = '{cnt: cnt3, adr: adr3};
    in_set_s[4] = '{cnt: cnt4, adr: adr4};
    in_set_s[5] = '{cnt: cnt5, adr: adr5};
    in_set_s[6] = '{cnt: cnt6, adr: adr6};
    in_set_s[7] = '{cnt: cnt7, adr: adr7};
    for (int k = 0; k < NCLUST_SET; k++) begin
      in_mask_s[k] = (in_set_s[k].adr != INVALID_ADR);
    end
  end

  assign rd_mask_s = mask_q[rd_bank_q];

  first_valid8 u_first_valid8 (
    .mask_i (rd_mask_s),
    .idx_o  (rd_idx_s),
    .any_o  (rd_any_s)
  );

  assign rd_word_s     = bank_q[rd_bank_q][rd_idx_s];
  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign rd_one_left_s = rd_any_s && ((rd_mask_s & (rd_mask_s - 8'd1)) == 8'd0);

`ifdef CLUSTER_SET_HEADER_EN
  assign hdr_active_s = hdr_pend_q[rd_bank_q];
  assign hdr_data_s   = hdr_word_q[rd_bank_q];
  assign capture_s    = in_valid;
`else
  assign hdr_active_s = 1'b0;
  assign hdr_data_s   = 14'd0;
  assign capture_s    = in_valid && (in_mask_s != 8'd0);
`endif

  // Output word selection; everything is held at zero while the read bank is empty.
  always_comb begin
    out_valid     = full_q[rd_bank_q];
    out_data      = 14'd0;
    out_last      = 1'b0;
    out_is_header = 1'b0;
    if (out_valid && hdr_active_s) begin
      out_data      = hdr_data_s;
      out_last      = !rd_any_s;
      out_is_header = 1'b1;
    end else if (out_valid) begin
      out_data      = rd_word_s;
      out_last      = rd_one_left_s;
    end else begin
      out_data      = 14'd0;
    end
  end

  assign handshake_s = out_valid && out_ready;
  assign release_s   = handshake_s && out_last;
  // A bank handed back this cycle may be refilled in the same cycle.
  assign bank_free_s = !full_q[wr_bank_q] || (release_s && (rd_bank_q == wr_bank_q));
  assign accept_s    = capture_s && bank_free_s;

  // Next-state: drain first, then capture, so a same-bank refill wins.
  always_comb begin
    mask_d     = mask_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = capture_s && !bank_free_s;
    ovf_cnt_d  = ovf_cnt_q;
`ifdef CLUSTER_SET_HEADER_EN
    hdr_pend_d = hdr_pend_q;
    hdr_word_d = hdr_word_q;
    seq_d      = seq_q;
`endif
    if (handshake_s && !hdr_active_s) begin
      mask_d[rd_bank_q][rd_idx_s] = 1'b0;
    end else begin
`ifdef CLUSTER_SET_HEADER_EN
      if (handshake_s) begin
        hdr_pend_d[rd_bank_q] = 1'b0;
      end else begin
        hdr_pend_d = hdr_pend_q;
      end
`endif
    end
    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end else begin
      rd_bank_d         = rd_bank_q;
    end
    if (accept_s) begin
      full_d[wr_bank_q] = 1'b1;
      mask_d[wr_bank_q] = in_mask_s;
      wr_bank_d         = !wr_bank_q;
`ifdef CLUSTER_SET_HEADER_EN
      hdr_pend_d[wr_bank_q] = 1'b1;
      hdr_word_d[wr_bank_q] = {3'b000, seq_q, popcount8(in_mask_s)};
      seq_d                 = seq_q + 7'd1;
`endif
    end else begin
      wr_bank_d = wr_bank_q;
    end
    if (overflow_d && !(&ovf_cnt_q)) begin
      ovf_cnt_d = ovf_cnt_q + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      mask_q[0]  <= 8'd0;
      mask_q[1]  <= 8'd0;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      mask_q     <= mask_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Cluster storage: the whole set is written into the target bank on accept.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NCLUST_SET; k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else if (accept_s) begin
      for (int k = 0; k < NCLUST_SET; k++) begin
        bank_q[wr_bank_q][k] <= in_set_s[k];
      end
    end
  end

`ifdef CLUSTER_SET_HEADER_EN
  // Header bookkeeping: pending flag and prepared header word per bank.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      hdr_pend_q    <= 2'b00;
      hdr_word_q[0] <= 14'd0;
      hdr_word_q[1] <= 14'd0;
      seq_q         <= 7'd0;
    end else begin
      hdr_pend_q    <= hdr_pend_d;
      hdr_word_q    <= hdr_word_d;
      seq_q         <= seq_d;
    end
  end
`endif

  assign overflow     = overflow_q;
  assign overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_cluster_set_serializer.sv
module tb_cluster_set_serializer;

`ifdef CLUSTER_SET_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [13:0] data;
    logic        last;
    logic        hdr;
  } word_t;

  logic        clock4x = 1'b0;
  logic        global_reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] adr [8];
  logic [2:0]  cnt [8];
  logic        out_valid, out_last, out_is_header, overflow;
  logic [13:0] out_data;
  logic [15:0] overflow_cnt;

  // reference model: flat stream of expected words, each set ends with last=1
  word_t       wq[$];
  logic        exp_ovf;
  logic [15:0] exp_cnt;
  logic [6:0]  seq_m;
  int          dut_hs;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clock4x = ~clock4x;

  cluster_set_serializer dut (
    .clock4x(clock4x), .global_reset_n(global_reset_n), .in_valid(in_valid),
    .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .adr3(adr[3]),
    .adr4(adr[4]), .adr5(adr[5]), .adr6(adr[6]), .adr7(adr[7]),
    .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]), .cnt3(cnt[3]),
    .cnt4(cnt[4]), .cnt5(cnt[5]), .cnt6(cnt[6]), .cnt7(cnt[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_is_header(out_is_header),
    .overflow(overflow), .overflow_cnt(overflow_cnt)
  );

  task automatic model_clear();
    wq.delete();
    exp_ovf = 1'b0;
    exp_cnt = 16'd0;
    seq_m   = 7'd0;
  endtask

  // append the words of the set currently on adr/cnt to the expected stream
  task automatic push_set();
    int    n;
    int    left;
    word_t w;
    n = 0;
    for (int k = 0; k < 8; k++) if (adr[k] != 11'h7FE) n++;
    if (HDR != 0) begin
      w.data = {3'b000, seq_m, 4'(n)};
      w.last = (n == 0);
      w.hdr  = 1'b1;
      wq.push_back(w);
      seq_m = seq_m + 7'd1;
    end
    left = n;
    for (int k = 0; k < 8; k++) begin
      if (adr[k] != 11'h7FE) begin
        left--;
        w.data = {cnt[k], adr[k]};
        w.last = (left == 0);
        w.hdr  = 1'b0;
        wq.push_back(w);
      end
    end
  endtask

  // one clock: drive, compare against the model, advance the model
  task automatic tick(input logic iv, input logic rdy);
    int   sets;
    int   n;
    logic hs, rel, cap, free;
    in_valid  = iv;
    out_ready = rdy;
    #1;
    n_tests++;
    if (out_valid !== (wq.size() > 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %0b want %0b at %0t", out_valid, wq.size() > 0, $time);
    end
    if (wq.size() > 0) begin
      n_tests++;
      if ({out_data, out_last, out_is_header} !== {wq[0].data, wq[0].last, wq[0].hdr}) begin
        n_fail++;
        $display("FAIL word: got data=%h last=%b hdr=%b want data=%h last=%b hdr=%b at %0t",
                 out_data, out_last, out_is_header, wq[0].data, wq[0].last, wq[0].hdr, $time);
      end
    end
    n_tests++;
    if (overflow !== exp_ovf || overflow_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL overflow: got %b/%0d want %b/%0d at %0t",
               overflow, overflow_cnt, exp_ovf, exp_cnt, $time);
    end
    if (out_valid === 1'b1 && rdy) dut_hs++;
    sets = 0;
    foreach (wq[i]) if (wq[i].last) sets++;
    n = 0;
    for (int k = 0; k < 8; k++) if (adr[k] != 11'h7FE) n++;
    hs   = (wq.size() > 0) && rdy;
    rel  = hs && wq[0].last;
    cap  = iv && ((n != 0) || (HDR != 0));
    free = (sets < 2) || rel;
    if (hs) void'(wq.pop_front());
    exp_ovf = 1'b0;
    if (cap && free) push_set();
    else if (cap) begin
      exp_ovf = 1'b1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clock4x);
    in_valid = 1'b0;
  endtask

  task automatic rand_set(input int pct);
    for (int k = 0; k < 8; k++) begin
      cnt[k] = 3'($urandom_range(7, 0));
      adr[k] = ($urandom_range(99, 0) < pct) ? 11'($urandom_range(2045, 0)) : 11'h7FE;
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (wq.size() > 0 && b > 0) begin
      tick(1'b0, 1'b1);
      b--;
    end
    n_tests++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words left, want 0", wq.size());
    end
  endtask

  task automatic do_reset();
    global_reset_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clock4x);
    global_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if ({out_valid, out_data, out_last, out_is_header, overflow, overflow_cnt} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b h=%b o=%b c=%0d want all 0",
               out_valid, out_data, out_last, out_is_header, overflow, overflow_cnt);
    end
    @(negedge clock4x);
  endtask

  task automatic test_basic();
    logic [10:0] ea [3];
    logic [2:0]  ec [3];
    ea[0] = 11'd5; ea[1] = 11'd200; ea[2] = 11'd1535;
    ec[0] = 3'd1;  ec[1] = 3'd2;    ec[2] = 3'd3;
    for (int k = 0; k < 8; k++) begin adr[k] = 11'h7FE; cnt[k] = 3'd7; end
    adr[0] = ea[0]; cnt[0] = ec[0];
    adr[3] = ea[1]; cnt[3] = ec[1];
    adr[7] = ea[2]; cnt[7] = ec[2];
    tick(1'b1, 1'b1);
    if (HDR != 0) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== {ec[i], ea[i]} || out_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, {ec[i], ea[i]}, i == 2);
      end
      tick(1'b0, 1'b1);
    end
  endtask

  task automatic test_empty_set();
    do_reset();
    for (int k = 0; k < 8; k++) begin adr[k] = 11'h7FE; cnt[k] = 3'(k); end
    tick(1'b1, 1'b0);
    #1;
    n_tests++;
    if (HDR != 0) begin
      if (out_valid !== 1'b1 || out_data !== 14'd0 || out_last !== 1'b1 || out_is_header !== 1'b1) begin
        n_fail++;
        $display("FAIL empty_header: got v=%b d=%h l=%b h=%b want 1/0000/1/1",
                 out_valid, out_data, out_last, out_is_header);
      end
    end else begin
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_ignored: got out_valid=%b want 0", out_valid);
      end
    end
    repeat (4) tick(1'b0, 1'b1);
    n_tests++;
    if (overflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL empty_ovf: got %0d want 0", overflow_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      rand_set(100);
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
    end
    n_tests++;
    if (overflow_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d want 1", overflow_cnt);
    end
    drain(40);
  endtask

  task automatic test_backpressure();
    int start;
    do_reset();
    rand_set(100);
    start = dut_hs;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'(i % 2));
    n_tests++;
    if (dut_hs - start !== 8 + HDR) begin
      n_fail++;
      $display("FAIL backpressure_words: got %0d want %0d", dut_hs - start, 8 + HDR);
    end
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    rand_set(100);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    rand_set(60);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    b = 20;
    while (wq.size() > 0 && !wq[0].last && b > 0) begin
      tick(1'b0, 1'b1);
      b--;
    end
    rand_set(100);
    tick(1'b1, 1'b1);
    #1;
    n_tests++;
    if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL release_collision: got ovf=%b cnt=%0d want 0/0", overflow, overflow_cnt);
    end
    drain(60);
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    rand_set(100);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    #2;
    global_reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got out_valid=%b want 0", out_valid);
    end
    model_clear();
    @(negedge clock4x);
    @(negedge clock4x);
    global_reset_n = 1'b1;
    rand_set(50);
    adr[2] = 11'd77;
    tick(1'b1, 1'b1);
    drain(20);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0 && $urandom_range(3, 0) != 0) begin
        rand_set($urandom_range(100, 0));
        tick(1'b1, $urandom_range(3, 0) != 0);
      end else begin
        tick(1'b0, $urandom_range(3, 0) != 0);
      end
    end
    drain(60);
  endtask

  initial begin
    dut_hs = 0;
    for (int k = 0; k < 8; k++) begin adr[k] = 11'h7FE; cnt[k] = 3'd0; end
    model_clear();
    test_reset();
    test_basic();
    test_empty_set();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
